// File: rtl/hs_pipe_chain.sv
// hs_pipe_chain: chain of valid/ready register stages, single-entry (comb ready) or skid (registered ready).
module hs_pipe_chain #(
  parameter int DATA_W = 3,
  parameter int STAGES = 2,
  parameter int REG_READY = 0,
  localparam int OCC_W = $clog2(2*STAGES+1)
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [OCC_W-1:0]  occupancy,
  output logic [15:0]       beat_cnt
);
  logic              en_q;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [15:0]       cnt_q;
  logic              in_x, out_x;
  logic [STAGES-1:0] in_v;
  logic [DATA_W-1:0] in_d [STAGES];
  assign in_x = s_valid && s_ready;
  assign out_x = m_valid && m_ready;
  assign occupancy = occ_q;
  assign beat_cnt = cnt_q;
  assign occ_d = (in_x && !out_x) ? occ_q + OCC_W'(1) :
                 (!in_x && out_x) ? occ_q - OCC_W'(1) : occ_q;
  // en_q keeps s_ready low until the first edge after reset release
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      en_q <= 1'b0;
      occ_q <= '0;
      cnt_q <= '0;
    end else begin
      en_q <= 1'b1;
      occ_q <= occ_d;
      cnt_q <= cnt_q + 16'(out_x);
    end
  if (REG_READY == 0) begin : g_comb
    logic [STAGES-1:0] v_q;
    logic [DATA_W-1:0] d_q [STAGES];
    logic [STAGES:0]   rdy;
    always_comb begin
      rdy = '0;
      rdy[STAGES] = m_ready;
      for (int k = STAGES-1; k >= 0; k--) rdy[k] = !v_q[k] || rdy[k+1];
    end
    always_comb begin
      in_v = '0;
      in_d = '{default: '0};
      in_v[0] = in_x;
      in_d[0] = s_data;
      for (int k = 1; k < STAGES; k++) begin
        in_v[k] = v_q[k-1];
        in_d[k] = d_q[k-1];
      end
    end
    assign s_ready = en_q && rdy[0];
    assign m_valid = v_q[STAGES-1];
    assign m_data = d_q[STAGES-1];
    always_ff @(posedge sys_clk or posedge rst)
      if (rst) begin
        v_q <= '0;
        for (int k = 0; k < STAGES; k++) d_q[k] <= '0;
      end else begin
        for (int k = 0; k < STAGES; k++)
          if (rdy[k]) begin
            v_q[k] <= in_v[k];
            if (in_v[k]) d_q[k] <= in_d[k];
          end
      end
  end else begin : g_skid
    logic [STAGES-1:0] mv_q, sv_q, dn;
    logic [DATA_W-1:0] md_q [STAGES];
    logic [DATA_W-1:0] sd_q [STAGES];
    always_comb begin
      dn = '0;
      in_v = '0;
      in_d = '{default: '0};
      for (int k = 0; k < STAGES-1; k++) dn[k] = !sv_q[k+1];
      dn[STAGES-1] = m_ready;
      in_v[0] = in_x;
      in_d[0] = s_data;
      for (int k = 1; k < STAGES; k++) begin
        in_v[k] = mv_q[k-1];
        in_d[k] = md_q[k-1];
      end
    end
    assign s_ready = en_q && !sv_q[0];
    assign m_valid = mv_q[STAGES-1];
    assign m_data = md_q[STAGES-1];
    // a full skid entry blocks new beats until it has moved into main
    always_ff @(posedge sys_clk or posedge rst)
      if (rst) begin
        mv_q <= '0;
        sv_q <= '0;
        for (int k = 0; k < STAGES; k++) begin
          md_q[k] <= '0;
          sd_q[k] <= '0;
        end
      end else begin
        for (int k = 0; k < STAGES; k++)
          if (sv_q[k]) begin
            if (dn[k]) begin
              md_q[k] <= sd_q[k];
              sv_q[k] <= 1'b0;
            end
          end else if (in_v[k]) begin
            if (!mv_q[k] || dn[k]) begin
              mv_q[k] <= 1'b1;
              md_q[k] <= in_d[k];
            end else begin
              sv_q[k] <= 1'b1;
              sd_q[k] <= in_d[k];
            end
          end else if (dn[k]) mv_q[k] <= 1'b0;
      end
  end
endmodule

// File: tb/tb_hs_pipe_chain.sv
// tb_hs_pipe_chain: directed tables plus multi-cycle sequences for both ready modes side by side.
module tb_hs_pipe_chain;
  typedef struct {
    logic       sv;
    logic [2:0] sd;
    logic       mr;
    logic       mv;
    logic [2:0] md;
    logic [2:0] occ;
    logic       sr;
  } vec_t;
  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sv = '0, mr = '0, srdy, mv;
  logic [2:0] sd [2];
  logic [2:0] md [2];
  logic [2:0] occ [2];
  logic [15:0] bc [2];
  int n_cmp = 0;
  int n_fail = 0;
  vec_t bp [7];
  vec_t sk [10];
  always #5 sys_clk = ~sys_clk;
  hs_pipe_chain #(.DATA_W(3), .STAGES(2), .REG_READY(0)) u_comb (
    .sys_clk(sys_clk), .rst(rst), .s_valid(sv[0]), .s_data(sd[0]), .s_ready(srdy[0]),
    .m_valid(mv[0]), .m_data(md[0]), .m_ready(mr[0]), .occupancy(occ[0]), .beat_cnt(bc[0]));
  hs_pipe_chain #(.DATA_W(3), .STAGES(2), .REG_READY(1)) u_skid (
    .sys_clk(sys_clk), .rst(rst), .s_valid(sv[1]), .s_data(sd[1]), .s_ready(srdy[1]),
    .m_valid(mv[1]), .m_data(md[1]), .m_ready(mr[1]), .occupancy(occ[1]), .beat_cnt(bc[1]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask
  function automatic vec_t mk(int a, int b, int c, int d, int e, int f, int g);
    vec_t v;
    v.sv = 1'(a); v.sd = 3'(b); v.mr = 1'(c);
    v.mv = 1'(d); v.md = 3'(e); v.occ = 3'(f); v.sr = 1'(g);
    return v;
  endfunction
  task automatic chk_rst(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_mvalid%0d", tag, i), 32'(mv[i]), 32'd0);
      chk($sformatf("%s_mdata%0d", tag, i), 32'(md[i]), 32'd0);
      chk($sformatf("%s_occ%0d", tag, i), 32'(occ[i]), 32'd0);
      chk($sformatf("%s_cnt%0d", tag, i), 32'(bc[i]), 32'd0);
      chk($sformatf("%s_sready%0d", tag, i), 32'(srdy[i]), 32'd0);
    end
  endtask
  // called 2 time units after an edge, so rst changes between edges
  task automatic do_reset(input int n);
    rst = 1'b1;
    sv = '0;
    mr = '0;
    #1;
    chk_rst("rst_async");
    repeat (n) @(posedge sys_clk);
    #2;
    chk_rst("rst_held");
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) chk($sformatf("rel_pre_sready%0d", i), 32'(srdy[i]), 32'd0);
    tick();
    for (int i = 0; i < 2; i++) chk($sformatf("rel_post_sready%0d", i), 32'(srdy[i]), 32'd1);
  endtask
  task automatic apply_vec(input int i, input string tag, input vec_t v);
    sv[i] = v.sv;
    sd[i] = v.sd;
    mr[i] = v.mr;
    tick();
    chk({tag, "_mvalid"}, 32'(mv[i]), 32'(v.mv));
    chk({tag, "_mdata"}, 32'(md[i]), 32'(v.md));
    chk({tag, "_occ"}, 32'(occ[i]), 32'(v.occ));
    chk({tag, "_sready"}, 32'(srdy[i]), 32'(v.sr));
  endtask
  task automatic rnd_run(input int i, input int ncyc, input int drain);
    logic [2:0] q [$];
    logic [2:0] hd;
    logic held;
    for (int c = 0; c < ncyc + drain; c++) begin
      sv[i] = (c < ncyc) ? 1'($urandom_range(0, 1)) : 1'b0;
      sd[i] = 3'($urandom_range(0, 7));
      mr[i] = (c < ncyc) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (mv[i] && mr[i]) begin
        chk($sformatf("rnd%0d_nonempty", i), 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) chk($sformatf("rnd%0d_data", i), 32'(md[i]), 32'(q.pop_front()));
      end
      if (sv[i] && srdy[i]) q.push_back(sd[i]);
      held = mv[i] && !mr[i];
      hd = md[i];
      @(posedge sys_clk);
      #2;
      chk($sformatf("rnd%0d_occ", i), 32'(occ[i]), 32'(q.size()));
      if (held) begin
        chk($sformatf("rnd%0d_hold_v", i), 32'(mv[i]), 32'd1);
        chk($sformatf("rnd%0d_hold_d", i), 32'(md[i]), 32'(hd));
      end
    end
    chk($sformatf("rnd%0d_drained", i), 32'(q.size()), 32'd0);
  endtask
  initial begin
    int nxt [2];
    int acc1 [2];
    int mv1 [2];
    int nout [2];
    int outs [2];
    logic [1:0] found;
    bp[0] = mk(1, 1, 0, 0, 0, 1, 1);
    bp[1] = mk(1, 2, 0, 1, 1, 2, 0);
    bp[2] = mk(1, 3, 0, 1, 1, 2, 0);
    bp[3] = mk(1, 3, 1, 1, 2, 2, 1);
    bp[4] = mk(0, 0, 0, 1, 2, 2, 0);
    bp[5] = mk(0, 0, 1, 1, 3, 1, 1);
    bp[6] = mk(0, 0, 1, 0, 3, 0, 1);
    sk[0] = mk(1, 1, 0, 0, 0, 1, 1);
    sk[1] = mk(1, 2, 0, 1, 1, 2, 1);
    sk[2] = mk(1, 3, 0, 1, 1, 3, 1);
    sk[3] = mk(1, 4, 0, 1, 1, 4, 0);
    sk[4] = mk(1, 5, 0, 1, 1, 4, 0);
    sk[5] = mk(1, 6, 0, 1, 1, 4, 0);
    sk[6] = mk(0, 0, 1, 1, 2, 3, 0);
    sk[7] = mk(0, 0, 1, 1, 3, 2, 1);
    sk[8] = mk(0, 0, 1, 1, 4, 1, 1);
    sk[9] = mk(0, 0, 1, 0, 4, 0, 1);
    sd[0] = '0;
    sd[1] = '0;
    rst = 1'b1;
    tick();
    do_reset(3);
    // streaming 0..7 with m_ready high, both modes
    mr = '1;
    for (int i = 0; i < 2; i++) begin
      nxt[i] = 0; acc1[i] = -1; mv1[i] = -1; nout[i] = 0;
    end
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < 2; i++) begin
        sv[i] = nxt[i] < 8;
        sd[i] = 3'(nxt[i]);
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        if (mv[i] && mr[i]) begin
          if (mv1[i] < 0) mv1[i] = c;
          chk($sformatf("stream%0d_data%0d", i, nout[i]), 32'(md[i]), 32'(nout[i]));
          chk($sformatf("stream%0d_cycle%0d", i, nout[i]), 32'(c), 32'(mv1[i] + nout[i]));
          nout[i]++;
        end
        if (sv[i] && srdy[i]) begin
          if (acc1[i] < 0) acc1[i] = c;
          nxt[i]++;
        end
      end
      @(posedge sys_clk);
      #2;
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("stream%0d_latency", i), 32'(mv1[i] - acc1[i]), 32'd2);
      chk($sformatf("stream%0d_count", i), 32'(nout[i]), 32'd8);
      chk($sformatf("stream%0d_cnt", i), 32'(bc[i]), 32'd8);
    end
    // fill with downstream stalled, then reset mid-operation
    mr = '0;
    for (int b = 1; b <= 3; b++) begin
      sv = '1;
      sd[0] = 3'(b);
      sd[1] = 3'(b);
      tick();
    end
    chk("prefill_occ0", 32'(occ[0]), 32'd2);
    chk("prefill_occ1", 32'(occ[1]), 32'd3);
    do_reset(3);
    sv = '1; mr = '1;
    sd[0] = 3'd5;
    sd[1] = 3'd5;
    tick();
    sv = '0;
    found = '0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 2; i++)
        if (!found[i] && mv[i]) begin
          chk($sformatf("post_rst_first%0d", i), 32'(md[i]), 32'd5);
          found[i] = 1'b1;
        end
      tick();
    end
    for (int i = 0; i < 2; i++) chk($sformatf("post_rst_seen%0d", i), 32'(found[i]), 32'd1);
    do_reset(3);
    for (int r = 0; r < 7; r++) apply_vec(0, $sformatf("bp%0d", r), bp[r]);
    chk("bp_cnt", 32'(bc[0]), 32'd3);
    do_reset(3);
    for (int r = 0; r < 10; r++) apply_vec(1, $sformatf("sk%0d", r), sk[r]);
    chk("sk_cnt", 32'(bc[1]), 32'd4);
    do_reset(2);
    rnd_run(0, 400, 40);
    rnd_run(1, 400, 40);
    do_reset(2);
    // 65536 back-to-back output transfers on both chains
    sv = '1; mr = '1;
    outs[0] = 0;
    outs[1] = 0;
    for (int c = 0; c < 70000 && (outs[0] < 65536 || outs[1] < 65536); c++) begin
      sd[0] = 3'(c);
      sd[1] = 3'(c);
      #1;
      for (int i = 0; i < 2; i++) if (mv[i] && mr[i]) outs[i]++;
      @(posedge sys_clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        if (outs[i] == 65535) chk($sformatf("wrap%0d_ffff", i), 32'(bc[i]), 32'hffff);
        if (outs[i] == 65536) chk($sformatf("wrap%0d_zero", i), 32'(bc[i]), 32'd0);
      end
    end
    sv = '0;
    for (int i = 0; i < 2; i++) chk($sformatf("wrap%0d_reached", i), 32'(outs[i] >= 65536), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hs_pipe_chain.md
HS_PIPE_CHAIN -- requirements
Module: hs_pipe_chain

Interface
REQ-001 Parameter DATA_W, default 3: payload width in bits, legal range 1..64.
REQ-002 Parameter STAGES, default 2: number of register stages, legal range 1..8.
REQ-003 Parameter REG_READY, default 0: 0 = single-entry stages with combinational ready; 1 = two-entry skid stages with registered ready.
REQ-004 sys_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 s_valid  in  1  upstream beat valid.
REQ-007 s_data  in  DATA_W  upstream payload.
REQ-008 s_ready  out  1  block can accept a beat this cycle.
REQ-009 m_valid  out  1  downstream beat valid.
REQ-010 m_data  out  DATA_W  downstream payload.
REQ-011 m_ready  in  1  downstream accepts this cycle.
REQ-012 occupancy  out  OCC_W = clog2(2*STAGES+1)  number of beats currently held.
REQ-013 beat_cnt  out  16  count of completed output transfers.

Function
REQ-014 Input transfer occurs when s_valid && s_ready at a clock edge; output transfer occurs when m_valid && m_ready at a clock edge.
REQ-015 Beats leave in acceptance order; no beat is dropped, duplicated or altered.
REQ-016 Once m_valid is high, m_valid and m_data remain stable until the output transfer completes.
REQ-017 Stage k passes its beat to stage k+1 when k+1 is empty or k+1 transfers in the same cycle.
REQ-018 Latency: a beat accepted into an empty chain at edge N reaches m_valid=1 after edge N+STAGES-1, i.e. it is presented STAGES cycles after acceptance.
REQ-019 Throughput: with m_ready held high, one beat per cycle is sustained in both modes.
REQ-020 REG_READY=0: capacity STAGES; s_ready = first stage empty || first stage transferring onward in this cycle (combinational through the chain from m_ready).
REQ-021 REG_READY=0: with a full chain and m_ready=1, accept-in and transfer-out occur in the same cycle and occupancy is unchanged.
REQ-022 REG_READY=1: each stage holds a main entry and a skid entry; capacity 2*STAGES; stage ready is a flop equal to "skid entry empty"; no combinational path from m_ready to s_ready.
REQ-023 REG_READY=1: a beat arriving while the main entry is stalled is written to the skid entry; ready drops on the following edge; the skid entry drains into the main entry before any new beat is accepted.
REQ-024 occupancy = input transfers - output transfers since reset; it increments, decrements or holds, and holds when both transfers occur in the same cycle.
REQ-025 occupancy never exceeds capacity; s_ready is 0 whenever occupancy equals capacity and no output transfer occurs that cycle.
REQ-026 beat_cnt increments by 1 on each output transfer and wraps from 65535 to 0.
REQ-027 Empty chain: m_valid=0 and m_data holds its last value; s_valid with s_ready=0 has no effect.

Reset
REQ-028 While rst=1: all stage valid flags = 0, m_valid=0, m_data=0, occupancy=0, beat_cnt=0, s_ready=0.
REQ-029 rst takes effect immediately, without waiting for a clock edge; held beats are discarded.
REQ-030 s_ready = 1 from the first clock edge after rst deasserts.

Verification
REQ-031 Reset: rst=1 for 3 cycles, mid-stream -> m_valid=0, m_data=0, occupancy=0, beat_cnt=0, s_ready=0; one edge after release -> s_ready=1.
REQ-032 Streaming, DATA_W=3, STAGES=2, both modes: s_valid=1 with data 0..7, m_ready=1 -> first m_valid 2 cycles after first accept, m_data 0..7 on consecutive cycles, beat_cnt=8.
REQ-033 Backpressure, REG_READY=0, STAGES=2: m_ready=0, push 1,2,3 -> 1 and 2 held, occupancy=2, s_ready=0; m_ready=1 for one cycle -> 1 out, 3 accepted same cycle, occupancy stays 2.
REQ-034 Skid, REG_READY=1, STAGES=2: m_ready=0, s_valid=1 with data 1..6 -> exactly 4 accepted, occupancy=4, s_ready=0; m_ready=1 -> outputs 1,2,3,4 in order, s_ready=1 one edge after the first drain.
REQ-035 Wrap: 65536 output transfers -> beat_cnt=0; a random-stall run with m_ready and s_valid each 50% -> output sequence equals input sequence.
REQ-036 Async reset mid-operation: occupancy=3, assert rst between edges -> m_valid=0 and occupancy=0 before the next edge; after release, the first output is the first beat pushed after reset.
